// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU datapath types. Holds the word type and the state encoding of
// the memory-stage request controller (mem_req_ctrl).
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int CPU_WORD_W = 32;

  typedef logic [CPU_WORD_W-1:0] word_t;

  // IDLE: accept EX/MEM contents; REQ: dcache access outstanding;
  // DONE: one-cycle writeback slot; HALT: terminal until reset.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } memreq_state_t;

endpackage

// File: rtl/mem_perf_cnt.sv
// ---------------------------------------------------------------------------
// mem_perf_cnt
// Two free-running performance counters for the memory-stage controller.
// Only compiled when MEM_PERF_EN is defined.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_start_i       a request is being issued this cycle (IDLE->REQ)
//   req_cycle_i       controller is in REQ this cycle
//   perf_req_o        number of requests issued (wraps at 2^PERF_W)
//   perf_stall_o      number of cycles spent in REQ (wraps at 2^PERF_W)
// ---------------------------------------------------------------------------
`ifdef MEM_PERF_EN
module mem_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_start_i,
  input  logic              req_cycle_i,
  output logic [PERF_W-1:0] perf_req_o,
  output logic [PERF_W-1:0] perf_stall_o
);

  logic [PERF_W-1:0] req_cnt_q, req_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  // Next counter values; plain binary add wraps naturally.
  always_comb begin
    req_cnt_d   = req_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (req_start_i) begin
      req_cnt_d = req_cnt_q + PERF_W'(1);
    end else begin
      req_cnt_d = req_cnt_q;
    end
    if (req_cycle_i) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      req_cnt_q   <= req_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_req_o   = req_cnt_q;
  assign perf_stall_o = stall_cnt_q;

endmodule
`endif

// File: rtl/mem_req_ctrl_chk.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl_chk
// Simulation checks on the memory ops accepted by mem_req_ctrl.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   capture_i       controller is accepting a mem op this cycle
//   dren_i, dwen_i  load / store flags of that op
//   addr_lo_i       low two bits of the effective address
// ---------------------------------------------------------------------------
module mem_req_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic       capture_i,
  input logic       dren_i,
  input logic       dwen_i,
  input logic [1:0] addr_lo_i
);

  // Load and store together is illegal (the controller lets the store win).
  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    capture_i |-> !(dren_i && dwen_i));

  // Word accesses only; the address itself is passed through untouched.
  a_word_aligned: assert property (@(posedge clk) disable iff (rst)
    capture_i |-> (addr_lo_i == 2'b00));

endmodule

// File: rtl/mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl
// Memory-stage request controller. Issues a data-cache request from the
// EX/MEM latch contents, holds it until dhit, and produces the MEM/WB latch
// inputs. Upstream latches are stalled while an access is outstanding.
// Optional feature macro: MEM_PERF_EN adds the PERF_W parameter and the
// perf_req_o / perf_stall_o counter outputs (sub-module mem_perf_cnt).
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   dren_i, dwen_i        EX/MEM load / store flags
//   daddr_i, dstore_i     EX/MEM effective address / store data
//   halt_i, flush_i       EX/MEM halt, squash of the mem-stage instruction
//   dhit, dmemload        dcache completion and load data
//   dmemREN, dmemWEN      dcache read / write request
//   dmemaddr, dmemstore   dcache address / store data
//   dload_o               load data to MEM/WB
//   memory_en             MEM/WB latch enable
//   flush_o, halt_o       MEM/WB bubble insert / halt
//   stall_o               hold IF/ID, ID/EX, EX/MEM
// ---------------------------------------------------------------------------
module mem_req_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = CPU_WORD_W
`ifdef MEM_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dren_i,
  input  logic              dwen_i,
  input  logic [WORD_W-1:0] daddr_i,
  input  logic [WORD_W-1:0] dstore_i,
  input  logic              halt_i,
  input  logic              flush_i,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] dload_o,
  output logic              memory_en,
  output logic              flush_o,
  output logic              halt_o,
  output logic              stall_o
`ifdef MEM_PERF_EN
  , output logic [PERF_W-1:0] perf_req_o
  , output logic [PERF_W-1:0] perf_stall_o
`endif
);

  memreq_state_t     state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              squash_q, squash_d;
  logic [WORD_W-1:0] dload_q, dload_d;

  logic mem_op;
  logic capture;

  assign mem_op  = dren_i | dwen_i;
  // A mem op is only taken when it is neither squashed nor a halt.
  assign capture = (state_q == IDLE) & mem_op & ~flush_i & ~halt_i;

  // State and capture registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      squash_q   <= 1'b0;
      dload_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      squash_q   <= squash_d;
      dload_q    <= dload_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (halt_i) begin
          state_d = HALT;
        end else if (mem_op) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dhit) begin
          state_d = DONE;
        end else begin
          state_d = REQ;
        end
      end
      DONE:    state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Capture of the request, sticky squash and load-data latch.
  always_comb begin
    is_store_d = is_store_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    squash_d   = squash_q;
    dload_d    = dload_q;
    if (capture) begin
      // dwen_i decides the type, so a store wins over a simultaneous load.
      is_store_d = dwen_i;
      addr_d     = daddr_i;
      wdata_d    = dstore_i;
    end else begin
      is_store_d = is_store_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
    end
    case (state_q)
      // The access is never abandoned; a flush only marks it for a bubble.
      REQ:     squash_d = squash_q | flush_i;
      DONE:    squash_d = 1'b0;
      default: squash_d = squash_q;
    endcase
    if ((state_q == REQ) && dhit && !is_store_q) begin
      dload_d = dmemload;
    end else begin
      dload_d = dload_q;
    end
  end

  // Output logic: Moore except in IDLE, where the pipeline sees the
  // decision on the current EX/MEM contents in the same cycle.
  always_comb begin
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    dmemaddr  = '0;
    dmemstore = '0;
    memory_en = 1'b0;
    flush_o   = 1'b0;
    halt_o    = 1'b0;
    stall_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          memory_en = 1'b1;
          flush_o   = 1'b1;
        end else if (halt_i) begin
          memory_en = 1'b1;
          halt_o    = 1'b1;
        end else if (mem_op) begin
          stall_o   = 1'b1;
        end else begin
          memory_en = 1'b1;
        end
      end
      REQ: begin
        dmemREN   = ~is_store_q;
        dmemWEN   = is_store_q;
        dmemaddr  = addr_q;
        dmemstore = wdata_q;
        stall_o   = 1'b1;
      end
      DONE: begin
        memory_en = 1'b1;
        flush_o   = squash_q;
      end
      HALT: begin
        stall_o   = 1'b1;
        halt_o    = 1'b1;
      end
      default: begin
        memory_en = 1'b0;
      end
    endcase
  end

  assign dload_o = dload_q;

  mem_req_ctrl_chk u_chk (
    .clk       (CLK),
    .rst       (RST),
    .capture_i (capture),
    .dren_i    (dren_i),
    .dwen_i    (dwen_i),
    .addr_lo_i (daddr_i[1:0])
  );

`ifdef MEM_PERF_EN
  mem_perf_cnt #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk          (CLK),
    .rst          (RST),
    .req_start_i  (capture),
    .req_cycle_i  (state_q == REQ),
    .perf_req_o   (perf_req_o),
    .perf_stall_o (perf_stall_o)
  );
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_req_ctrl
// Self-checking bench for mem_req_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model of the memory stage.
// ---------------------------------------------------------------------------
module tb_mem_req_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        dren_i = 1'b0, dwen_i = 1'b0, halt_i = 1'b0, flush_i = 1'b0, dhit = 1'b0;
  logic [31:0] daddr_i = 32'h0, dstore_i = 32'h0, dmemload = 32'h0;
  logic        dmemREN, dmemWEN, memory_en, flush_o, halt_o, stall_o;
  logic [31:0] dmemaddr, dmemstore, dload_o;
`ifdef MEM_PERF_EN
  logic [31:0] perf_req_o, perf_stall_o;
`endif

  int n_err = 0;
  int n_checks = 0;

  mem_req_ctrl dut (
    .CLK(CLK), .RST(RST), .dren_i(dren_i), .dwen_i(dwen_i), .daddr_i(daddr_i),
    .dstore_i(dstore_i), .halt_i(halt_i), .flush_i(flush_i), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dload_o(dload_o), .memory_en(memory_en), .flush_o(flush_o),
    .halt_o(halt_o), .stall_o(stall_o)
`ifdef MEM_PERF_EN
    , .perf_req_o(perf_req_o), .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // An access is either waiting for the cache (busy), in its single
  // writeback cycle (finish), or absent; a halt freezes everything.
  logic        m_halted = 1'b0, m_busy = 1'b0, m_finish = 1'b0, m_store = 1'b0, m_squash = 1'b0;
  logic [31:0] m_addr = 32'h0, m_data = 32'h0, m_dload = 32'h0;
  logic [31:0] m_req_cnt = 32'h0, m_stall_cnt = 32'h0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_halted <= 1'b0; m_busy <= 1'b0; m_finish <= 1'b0; m_store <= 1'b0;
      m_squash <= 1'b0; m_addr <= 32'h0; m_data <= 32'h0; m_dload <= 32'h0;
      m_req_cnt <= 32'h0; m_stall_cnt <= 32'h0;
    end else if (m_halted) begin
    end else if (m_busy) begin
      m_stall_cnt <= m_stall_cnt + 32'd1;
      if (flush_i) m_squash <= 1'b1;
      if (dhit) begin
        m_busy <= 1'b0;
        m_finish <= 1'b1;
        if (!m_store) m_dload <= dmemload;
      end
    end else if (m_finish) begin
      m_finish <= 1'b0;
      m_squash <= 1'b0;
    end else if (flush_i) begin
    end else if (halt_i) begin
      m_halted <= 1'b1;
    end else if (dren_i || dwen_i) begin
      m_busy <= 1'b1;
      m_store <= dwen_i;
      m_addr <= daddr_i;
      m_data <= dstore_i;
      m_req_cnt <= m_req_cnt + 32'd1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge CLK) begin
    logic e_ren, e_wen, e_men, e_fl, e_ht, e_st;
    logic [31:0] e_addr, e_data;
    e_ren = 1'b0; e_wen = 1'b0; e_men = 1'b0; e_fl = 1'b0; e_ht = 1'b0; e_st = 1'b0;
    e_addr = 32'h0; e_data = 32'h0;
    if (m_halted) begin
      e_ht = 1'b1; e_st = 1'b1;
    end else if (m_busy) begin
      e_ren = !m_store; e_wen = m_store; e_addr = m_addr; e_data = m_data; e_st = 1'b1;
    end else if (m_finish) begin
      e_men = 1'b1; e_fl = m_squash;
    end else if (flush_i) begin
      e_men = 1'b1; e_fl = 1'b1;
    end else if (halt_i) begin
      e_men = 1'b1; e_ht = 1'b1;
    end else if (dren_i || dwen_i) begin
      e_st = 1'b1;
    end else begin
      e_men = 1'b1;
    end
    check("dmemREN", {31'b0, dmemREN}, {31'b0, e_ren});
    check("dmemWEN", {31'b0, dmemWEN}, {31'b0, e_wen});
    check("dmemaddr", dmemaddr, e_addr);
    check("dmemstore", dmemstore, e_data);
    check("memory_en", {31'b0, memory_en}, {31'b0, e_men});
    check("flush_o", {31'b0, flush_o}, {31'b0, e_fl});
    check("halt_o", {31'b0, halt_o}, {31'b0, e_ht});
    check("stall_o", {31'b0, stall_o}, {31'b0, e_st});
    check("dload_o", dload_o, m_dload);
`ifdef MEM_PERF_EN
    check("perf_req_o", perf_req_o, m_req_cnt);
    check("perf_stall_o", perf_stall_o, m_stall_cnt);
`endif
  end

  // ---------------- directed helpers ----------------
  task automatic idle_inputs();
    dren_i = 1'b0; dwen_i = 1'b0; halt_i = 1'b0; flush_i = 1'b0; dhit = 1'b0;
    daddr_i = 32'h0; dstore_i = 32'h0; dmemload = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Runs one access with dhit in REQ cycle number wait_n (1 = first) and an
  // optional flush in REQ cycle flush_at; lat counts cycles from capture up
  // to and including the cycle where memory_en returns.
  task automatic do_access(input bit st, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] ld, input int wait_n, input int flush_at,
                           output int ren_c, output int wen_c, output int stall_c,
                           output int lat, output logic flush_seen,
                           output logic [31:0] addr_seen, output logic [31:0] data_seen);
    ren_c = 0; wen_c = 0; stall_c = 0; lat = 0; flush_seen = 1'b0;
    addr_seen = 32'h0; data_seen = 32'h0;
    for (int i = 0; i < wait_n + 6 && lat == 0; i++) begin
      dren_i   = (i == 0) && !st;
      dwen_i   = (i == 0) && st;
      daddr_i  = (i == 0) ? a : 32'h0;
      dstore_i = (i == 0) ? d : 32'h0;
      dhit     = (i == wait_n);
      dmemload = (i == wait_n) ? ld : $urandom();
      flush_i  = (i == flush_at);
      #3;
      ren_c += int'(dmemREN);
      wen_c += int'(dmemWEN);
      stall_c += int'(stall_o);
      if (dmemREN || dmemWEN) begin
        addr_seen = dmemaddr;
        data_seen = dmemstore;
      end
      if (i > 0 && memory_en) begin
        lat = i + 1;
        flush_seen = flush_o;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    next_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rc, wc, sc, lat, hc, halt_cnt;
    logic fs;
    logic [31:0] as, ds, tmp;
    int op;

    idle_inputs();
    #3;
    // Reset state
    check("rst_dmemREN", {31'b0, dmemREN}, 32'd0);
    check("rst_memory_en", {31'b0, memory_en}, 32'd1);
    check("rst_dload", dload_o, 32'h0);
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    next_cycle();
    RST = 1'b0;
    next_cycle();

    // 1: load, dhit in second REQ cycle
    do_access(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 2, -1, rc, wc, sc, lat, fs, as, ds);
    check("t1_ren_cycles", rc, 32'd2);
    check("t1_stall_cycles", sc, 32'd3);
    check("t1_latency", lat, 32'd4);
    check("t1_addr", as, 32'h0000_0040);
    check("t1_dload", dload_o, 32'hDEAD_BEEF);
    check("t1_model_dload", m_dload, 32'hDEAD_BEEF);

    // 2: store, dhit in first REQ cycle
    do_access(1'b1, 32'h0000_0080, 32'h1234_5678, 32'h5555_AAAA, 1, -1, rc, wc, sc, lat, fs, as, ds);
    check("t2_wen_cycles", wc, 32'd1);
    check("t2_ren_cycles", rc, 32'd0);
    check("t2_addr", as, 32'h0000_0080);
    check("t2_store", ds, 32'h1234_5678);
    check("t2_latency", lat, 32'd3);
    check("t2_dload_kept", dload_o, 32'hDEAD_BEEF);

    // 3: flush during REQ of a load
    do_access(1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_0001, 3, 1, rc, wc, sc, lat, fs, as, ds);
    check("t3_ren_cycles", rc, 32'd3);
    check("t3_flush_in_done", {31'b0, fs}, 32'd1);
    check("t3_latency", lat, 32'd5);
    check("t3_dload", dload_o, 32'hCAFE_0001);

    // 4: halt with no mem op, then 20 halted cycles
    halt_i = 1'b1;
    #3;
    check("t4_halt_o", {31'b0, halt_o}, 32'd1);
    check("t4_memory_en", {31'b0, memory_en}, 32'd1);
    next_cycle();
    halt_i = 1'b0;
    hc = 0;
    for (int i = 0; i < 20; i++) begin
      dren_i = (i % 3 == 0);
      #3;
      if (stall_o && !memory_en && halt_o && !dmemREN) hc++;
      next_cycle();
    end
    idle_inputs();
    check("t4_halted_cycles", hc, 32'd20);
    pulse_reset();

    // 5: reset while in REQ
    dren_i = 1'b1; daddr_i = 32'h0000_0200;
    next_cycle();
    idle_inputs();
    #1;
    check("t5_ren_before", {31'b0, dmemREN}, 32'd1);
    RST = 1'b1;
    #1;
    check("t5_ren_drop", {31'b0, dmemREN}, 32'd0);
    next_cycle();
    RST = 1'b0;
    #1;
    check("t5_memory_en", {31'b0, memory_en}, 32'd1);
    next_cycle();
    do_access(1'b0, 32'h0000_0204, 32'h0, 32'h0BAD_F00D, 1, -1, rc, wc, sc, lat, fs, as, ds);
    check("t5_latency", lat, 32'd3);
    check("t5_dload", dload_o, 32'h0BAD_F00D);

`ifdef MEM_PERF_EN
    // 6: three loads with 4-cycle dhit delay
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      do_access(1'b0, 32'h0000_0300 + 32'(k * 4), 32'h0, 32'(k), 4, -1, rc, wc, sc, lat, fs, as, ds);
    end
    #3;
    check("t6_perf_req", perf_req_o, 32'd3);
    check("t6_perf_stall", perf_stall_o, 32'd12);
    next_cycle();
`endif

    // Randomized traffic, compared every cycle by the model process.
    halt_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_halted) halt_cnt++;
      else halt_cnt = 0;
      RST = (halt_cnt >= 8) || ($urandom_range(0, 399) == 0);
      op = $urandom_range(0, 9);
      dren_i = (op < 3);
      dwen_i = (op >= 3) && (op < 6);
      tmp = $urandom();
      daddr_i = {tmp[31:2], 2'b00};
      dstore_i = $urandom();
      dmemload = $urandom();
      dhit = ($urandom_range(0, 9) < 4);
      flush_i = ($urandom_range(0, 9) == 0);
      halt_i = ($urandom_range(0, 149) == 0);
      next_cycle();
    end
    RST = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
